// File: rtl/axi4_protocol_monitor.sv
// Passive AXI4 protocol monitor: handshake/payload stability, burst-length
// tracking, response legality, orphan/overflow detection, watchdogs and
// outstanding-burst accounting. Violations are reported as sticky bits.
module axi4_protocol_monitor #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned MAX_OUTST    = 4,
   parameter int unsigned B_TIMEOUT    = 256,
   parameter int unsigned R_TIMEOUT    = 256,
   parameter int unsigned ALLOW_DECERR = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                         ACLK,
   input  logic                         ARESETn,
   input  logic                         AWVALID,
   input  logic                         AWREADY,
   input  logic [ADDR_W-1:0]            AWADDR,
   input  logic [7:0]                   AWLEN,
   input  logic                         WVALID,
   input  logic                         WREADY,
   input  logic [DATA_W-1:0]            WDATA,
   input  logic                         WLAST,
   input  logic                         BVALID,
   input  logic                         BREADY,
   input  logic [1:0]                   BRESP,
   input  logic                         ARVALID,
   input  logic                         ARREADY,
   input  logic [ADDR_W-1:0]            ARADDR,
   input  logic [7:0]                   ARLEN,
   input  logic                         RVALID,
   input  logic                         RREADY,
   input  logic [DATA_W-1:0]            RDATA,
   input  logic                         RLAST,
   input  logic [1:0]                   RRESP,
   input  logic                         clr_err,
   output logic [11:0]                  err_vec,
   output logic                         err_pulse,
   output logic [3:0]                   first_err,
   output logic [CNT_W-1:0]             wr_done,
   output logic [CNT_W-1:0]             rd_done,
   output logic [$clog2(MAX_OUTST):0]   wr_outst,
   output logic [$clog2(MAX_OUTST):0]   rd_outst
);

   localparam int unsigned PW = $clog2(MAX_OUTST);
   localparam int unsigned OW = PW + 1;
   localparam int unsigned BW = $clog2(B_TIMEOUT + 1);
   localparam int unsigned RW = $clog2(R_TIMEOUT + 1);

   function automatic logic bad_resp(input logic [1:0] resp);
      return (resp == 2'b01) || ((resp == 2'b11) && (ALLOW_DECERR == 0));
   endfunction

   logic hs_aw, hs_w, hs_b, hs_ar, hs_r;
   assign hs_aw = AWVALID & AWREADY;
   assign hs_w  = WVALID  & WREADY;
   assign hs_b  = BVALID  & BREADY;
   assign hs_ar = ARVALID & ARREADY;
   assign hs_r  = RVALID  & RREADY;

   // ---------------- stall / payload history ----------------
   logic aw_stall_q, w_stall_q, b_stall_q, ar_stall_q, r_stall_q;
   logic [ADDR_W+7:0] aw_pl_q, ar_pl_q;
   logic [DATA_W:0]   w_pl_q;
   logic [DATA_W+2:0] r_pl_q;
   logic [1:0]        b_pl_q;

   // Remember last cycle's stall state and payload of every channel
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         aw_stall_q <= 1'b0; w_stall_q <= 1'b0; b_stall_q <= 1'b0;
         ar_stall_q <= 1'b0; r_stall_q <= 1'b0;
         aw_pl_q <= '0; ar_pl_q <= '0; w_pl_q <= '0; r_pl_q <= '0; b_pl_q <= '0;
      end else begin
         aw_stall_q <= AWVALID & ~AWREADY;
         w_stall_q  <= WVALID  & ~WREADY;
         b_stall_q  <= BVALID  & ~BREADY;
         ar_stall_q <= ARVALID & ~ARREADY;
         r_stall_q  <= RVALID  & ~RREADY;
         aw_pl_q    <= {AWADDR, AWLEN};
         ar_pl_q    <= {ARADDR, ARLEN};
         w_pl_q     <= {WDATA, WLAST};
         r_pl_q     <= {RDATA, RLAST, RRESP};
         b_pl_q     <= BRESP;
      end
   end

   // ---------------- write side ----------------
   logic [7:0]    aw_mem [MAX_OUTST];
   logic [PW-1:0] aw_wp, aw_rp;
   logic [OW-1:0] aw_cnt, wr_pend;
   logic [7:0]    w_beat;
   logic          aw_empty, aw_full, w_act, w_last_exp, w_pop, w_lerr, w_orph;
   logic          aw_ovf, aw_wr, aw_rd, b_orph, b_ok;
   logic [7:0]    w_len;

   assign aw_empty   = (aw_cnt == '0);
   assign aw_full    = (aw_cnt == OW'(MAX_OUTST));
   // An AW accepted together with the first W of an empty queue is used directly
   assign w_len      = aw_empty ? AWLEN : aw_mem[aw_rp];
   assign w_act      = hs_w & (~aw_empty | hs_aw);
   assign w_orph     = hs_w & aw_empty & ~hs_aw;
   assign w_last_exp = (w_beat == w_len);
   assign w_pop      = w_act & (WLAST | w_last_exp);
   assign w_lerr     = w_act & (WLAST != w_last_exp);
   assign aw_ovf     = hs_aw & aw_full & ~w_pop;
   assign aw_wr      = hs_aw & ~aw_ovf & ~(aw_empty & w_pop);
   assign aw_rd      = w_pop & ~aw_empty;
   assign b_orph     = hs_b & (wr_pend == '0);
   assign b_ok       = hs_b & ~b_orph;

   // Store accepted AWLEN values
   always_ff @(posedge ACLK) begin
      if (aw_wr) aw_mem[aw_wp] <= AWLEN;
   end

   // Write burst tracking: queue pointers, beat counter, awaiting-B count
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         aw_wp <= '0; aw_rp <= '0; aw_cnt <= '0;
         w_beat <= '0; wr_pend <= '0; wr_done <= '0;
      end else begin
         if (aw_wr) aw_wp <= aw_wp + 1'b1;
         if (aw_rd) aw_rp <= aw_rp + 1'b1;
         aw_cnt <= aw_cnt + OW'(aw_wr) - OW'(aw_rd);
         if (w_pop)      w_beat <= '0;
         else if (w_act) w_beat <= w_beat + 1'b1;
         if (w_pop && !b_ok && wr_pend != '1) wr_pend <= wr_pend + 1'b1;
         else if (!w_pop && b_ok)             wr_pend <= wr_pend - 1'b1;
         if (b_ok) wr_done <= wr_done + 1'b1;
      end
   end

   // ---------------- read side ----------------
   logic [7:0]    ar_mem [MAX_OUTST];
   logic [PW-1:0] ar_wp, ar_rp;
   logic [OW-1:0] ar_cnt;
   logic [7:0]    r_beat;
   logic          ar_empty, ar_full, r_act, r_last_exp, r_pop, r_lerr, r_orph;
   logic          ar_ovf, ar_wr, ar_rd;
   logic [7:0]    r_len;

   assign ar_empty   = (ar_cnt == '0);
   assign ar_full    = (ar_cnt == OW'(MAX_OUTST));
   assign r_len      = ar_empty ? ARLEN : ar_mem[ar_rp];
   assign r_act      = hs_r & (~ar_empty | hs_ar);
   assign r_orph     = hs_r & ar_empty & ~hs_ar;
   assign r_last_exp = (r_beat == r_len);
   assign r_pop      = r_act & (RLAST | r_last_exp);
   assign r_lerr     = r_act & (RLAST != r_last_exp);
   assign ar_ovf     = hs_ar & ar_full & ~r_pop;
   assign ar_wr      = hs_ar & ~ar_ovf & ~(ar_empty & r_pop);
   assign ar_rd      = r_pop & ~ar_empty;

   // Store accepted ARLEN values
   always_ff @(posedge ACLK) begin
      if (ar_wr) ar_mem[ar_wp] <= ARLEN;
   end

   // Read burst tracking: queue pointers, beat counter, completions
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         ar_wp <= '0; ar_rp <= '0; ar_cnt <= '0; r_beat <= '0; rd_done <= '0;
      end else begin
         if (ar_wr) ar_wp <= ar_wp + 1'b1;
         if (ar_rd) ar_rp <= ar_rp + 1'b1;
         ar_cnt <= ar_cnt + OW'(ar_wr) - OW'(ar_rd);
         if (r_pop)      r_beat <= '0;
         else if (r_act) r_beat <= r_beat + 1'b1;
         if (r_pop) rd_done <= rd_done + 1'b1;
      end
   end

   // ---------------- watchdogs ----------------
   logic [BW-1:0] b_wd;
   logic [RW-1:0] r_wd;
   logic          b_to, r_to;

   assign b_to = ~hs_b & (wr_pend != '0) & (b_wd == BW'(B_TIMEOUT - 1));
   assign r_to = ~hs_r & ~ar_empty      & (r_wd == RW'(R_TIMEOUT - 1));

   // Saturating watchdogs; a timeout fires only on the step that reaches the limit
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         b_wd <= '0;
         r_wd <= '0;
      end else begin
         if (hs_b)                                          b_wd <= '0;
         else if (wr_pend != '0 && b_wd != BW'(B_TIMEOUT)) b_wd <= b_wd + 1'b1;
         if (hs_r)                                          r_wd <= '0;
         else if (!ar_empty && r_wd != RW'(R_TIMEOUT))     r_wd <= r_wd + 1'b1;
      end
   end

   // ---------------- error collection ----------------
   logic [11:0] new_err;
   logic [3:0]  first_new;

   // Gather this cycle's violations
   always_comb begin
      new_err     = '0;
      new_err[0]  = aw_stall_q & ~AWVALID;
      new_err[1]  = w_stall_q  & ~WVALID;
      new_err[2]  = ar_stall_q & ~ARVALID;
      new_err[3]  = r_stall_q  & ~RVALID;
      new_err[4]  = b_stall_q  & ~BVALID;
      new_err[5]  = (aw_stall_q & AWVALID & ({AWADDR, AWLEN} != aw_pl_q))
                  | (w_stall_q  & WVALID  & ({WDATA, WLAST} != w_pl_q))
                  | (ar_stall_q & ARVALID & ({ARADDR, ARLEN} != ar_pl_q))
                  | (r_stall_q  & RVALID  & ({RDATA, RLAST, RRESP} != r_pl_q))
                  | (b_stall_q  & BVALID  & (BRESP != b_pl_q));
      new_err[6]  = w_lerr;
      new_err[7]  = r_lerr;
      new_err[8]  = (hs_b & bad_resp(BRESP)) | (hs_r & bad_resp(RRESP));
      new_err[9]  = w_orph | b_orph | r_orph;
      new_err[10] = aw_ovf | ar_ovf;
      new_err[11] = b_to | r_to;
   end

   // Lowest set index of the new violations
   always_comb begin
      first_new = '0;
      for (int unsigned i = 0; i < 12; i++) begin
         if (new_err[11 - i]) first_new = 4'(11 - i);
      end
   end

   // Sticky error vector; a violation coinciding with clear survives it
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         err_vec   <= '0;
         err_pulse <= 1'b0;
         first_err <= '0;
      end else begin
         err_vec   <= (clr_err ? 12'h000 : err_vec) | new_err;
         err_pulse <= |new_err;
         if ((|new_err) && (clr_err || err_vec == '0)) first_err <= first_new;
         else if (clr_err)                             first_err <= '0;
      end
   end

   logic [OW:0] wr_sum;
   assign wr_sum   = {1'b0, aw_cnt} + {1'b0, wr_pend};
   assign wr_outst = wr_sum[OW] ? '1 : wr_sum[OW-1:0];
   assign rd_outst = ar_cnt;

endmodule

// File: tb/tb_axi4_protocol_monitor.sv
// Directed self-checking bench for axi4_protocol_monitor.
module tb_axi4_protocol_monitor;

   logic        ACLK, ARESETn;
   logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
   logic        ARVALID, ARREADY, RVALID, RREADY, RLAST, clr_err;
   logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
   logic [7:0]  AWLEN, ARLEN;
   logic [1:0]  BRESP, RRESP;
   logic [11:0] err_vec;
   logic        err_pulse;
   logic [3:0]  first_err;
   logic [15:0] wr_done, rd_done;
   logic [2:0]  wr_outst, rd_outst;

   int n_cmp = 0;
   int n_bad = 0;

   axi4_protocol_monitor #(
      .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .B_TIMEOUT(32),
      .R_TIMEOUT(32), .ALLOW_DECERR(1), .CNT_W(16)
   ) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
      .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
      .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP),
      .clr_err(clr_err), .err_vec(err_vec), .err_pulse(err_pulse), .first_err(first_err),
      .wr_done(wr_done), .rd_done(rd_done), .wr_outst(wr_outst), .rd_outst(rd_outst)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic cycle();
      @(posedge ACLK);
      #1;
   endtask

   task automatic idle_inputs();
      AWVALID = 0; AWREADY = 0; AWADDR = '0; AWLEN = '0;
      WVALID = 0; WREADY = 0; WDATA = '0; WLAST = 0;
      BVALID = 0; BREADY = 0; BRESP = '0;
      ARVALID = 0; ARREADY = 0; ARADDR = '0; ARLEN = '0;
      RVALID = 0; RREADY = 0; RDATA = '0; RLAST = 0; RRESP = '0;
      clr_err = 0;
   endtask

   task automatic aw_hs(input logic [7:0] len);
      AWVALID = 1; AWREADY = 1; AWLEN = len; AWADDR = 32'h1000;
      cycle();
      AWVALID = 0; AWREADY = 0;
   endtask

   task automatic w_hs(input logic last, input logic [31:0] data);
      WVALID = 1; WREADY = 1; WLAST = last; WDATA = data;
      cycle();
      WVALID = 0; WREADY = 0; WLAST = 0;
   endtask

   task automatic b_hs(input logic [1:0] resp);
      BVALID = 1; BREADY = 1; BRESP = resp;
      cycle();
      BVALID = 0; BREADY = 0; BRESP = '0;
   endtask

   task automatic ar_hs(input logic [7:0] len);
      ARVALID = 1; ARREADY = 1; ARLEN = len; ARADDR = 32'h2000;
      cycle();
      ARVALID = 0; ARREADY = 0;
   endtask

   task automatic r_hs(input logic last, input logic [1:0] resp);
      RVALID = 1; RREADY = 1; RLAST = last; RRESP = resp; RDATA = 32'hA5A5_0000;
      cycle();
      RVALID = 0; RREADY = 0; RLAST = 0; RRESP = '0;
   endtask

   task automatic pulse_clr();
      clr_err = 1;
      cycle();
      clr_err = 0;
   endtask

   task automatic test_reset();
      ARESETn = 0;
      idle_inputs();
      repeat (3) cycle();
      n_cmp++; if (err_vec !== 12'h000) begin n_bad++; $display("FAIL reset_err_vec: got %h want 000", err_vec); end
      n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_err_pulse: got %b want 0", err_pulse); end
      n_cmp++; if (first_err !== 4'd0) begin n_bad++; $display("FAIL reset_first_err: got %0d want 0", first_err); end
      n_cmp++; if (wr_done !== 16'd0 || rd_done !== 16'd0) begin n_bad++; $display("FAIL reset_done: got %0d/%0d want 0/0", wr_done, rd_done); end
      n_cmp++; if (wr_outst !== 3'd0 || rd_outst !== 3'd0) begin n_bad++; $display("FAIL reset_outst: got %0d/%0d want 0/0", wr_outst, rd_outst); end
      ARESETn = 1;
      cycle();
   endtask

   task automatic test_write_burst();
      aw_hs(8'd3);
      n_cmp++; if (wr_outst !== 3'd1) begin n_bad++; $display("FAIL wb_outst_after_aw: got %0d want 1", wr_outst); end
      for (int i = 0; i < 4; i++) w_hs(i == 3, 32'h100 + i);
      n_cmp++; if (wr_outst !== 3'd1) begin n_bad++; $display("FAIL wb_outst_after_w: got %0d want 1", wr_outst); end
      b_hs(2'b00);
      n_cmp++; if (err_vec !== 12'h000) begin n_bad++; $display("FAIL wb_err_vec: got %h want 000", err_vec); end
      n_cmp++; if (wr_done !== 16'd1) begin n_bad++; $display("FAIL wb_wr_done: got %0d want 1", wr_done); end
      n_cmp++; if (wr_outst !== 3'd0) begin n_bad++; $display("FAIL wb_outst_final: got %0d want 0", wr_outst); end
   endtask

   task automatic test_valid_drop();
      AWVALID = 1; AWREADY = 0; AWADDR = 32'h44; AWLEN = 8'd0;
      cycle();
      AWVALID = 0;
      cycle();
      n_cmp++; if (err_vec !== 12'h001) begin n_bad++; $display("FAIL drop_err_vec: got %h want 001", err_vec); end
      n_cmp++; if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL drop_pulse_hi: got %b want 1", err_pulse); end
      n_cmp++; if (first_err !== 4'd0) begin n_bad++; $display("FAIL drop_first_err: got %0d want 0", first_err); end
      cycle();
      n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL drop_pulse_lo: got %b want 0", err_pulse); end
      n_cmp++; if (err_vec !== 12'h001) begin n_bad++; $display("FAIL drop_sticky: got %h want 001", err_vec); end
      pulse_clr();
      n_cmp++; if (err_vec !== 12'h000) begin n_bad++; $display("FAIL drop_clr: got %h want 000", err_vec); end
      // payload change during a stall, then a drop: first_err keeps the earlier one
      ARVALID = 1; ARREADY = 0; ARADDR = 32'h10;
      cycle();
      ARADDR = 32'h20;
      cycle();
      n_cmp++; if (err_vec !== 12'h020 || first_err !== 4'd5) begin n_bad++; $display("FAIL payload_change: got %h/%0d want 020/5", err_vec, first_err); end
      ARVALID = 0;
      cycle();
      n_cmp++; if (err_vec !== 12'h024 || first_err !== 4'd5) begin n_bad++; $display("FAIL payload_then_drop: got %h/%0d want 024/5", err_vec, first_err); end
      pulse_clr();
      n_cmp++; if (err_vec !== 12'h000 || first_err !== 4'd0) begin n_bad++; $display("FAIL payload_clr: got %h/%0d want 000/0", err_vec, first_err); end
   endtask

   task automatic test_wlast_resync();
      aw_hs(8'd1);
      w_hs(1'b0, 32'h1);
      w_hs(1'b0, 32'h2);
      n_cmp++; if (err_vec !== 12'h040 || first_err !== 4'd6) begin n_bad++; $display("FAIL wlast_missing: got %h/%0d want 040/6", err_vec, first_err); end
      n_cmp++; if (wr_outst !== 3'd1) begin n_bad++; $display("FAIL wlast_resync_outst: got %0d want 1", wr_outst); end
      b_hs(2'b00);
      n_cmp++; if (wr_done !== 16'd2 || wr_outst !== 3'd0) begin n_bad++; $display("FAIL wlast_b: got %0d/%0d want 2/0", wr_done, wr_outst); end
      pulse_clr();
   endtask

   task automatic test_rlast();
      ar_hs(8'd1);
      n_cmp++; if (rd_outst !== 3'd1) begin n_bad++; $display("FAIL rlast_outst: got %0d want 1", rd_outst); end
      r_hs(1'b1, 2'b00);
      n_cmp++; if (err_vec !== 12'h080 || first_err !== 4'd7) begin n_bad++; $display("FAIL rlast_early: got %h/%0d want 080/7", err_vec, first_err); end
      n_cmp++; if (rd_done !== 16'd1 || rd_outst !== 3'd0) begin n_bad++; $display("FAIL rlast_pop: got %0d/%0d want 1/0", rd_done, rd_outst); end
      pulse_clr();
      ar_hs(8'd0);
      r_hs(1'b1, 2'b00);
      n_cmp++; if (err_vec !== 12'h000) begin n_bad++; $display("FAIL rlast_len0: got %h want 000", err_vec); end
      n_cmp++; if (rd_done !== 16'd2) begin n_bad++; $display("FAIL rlast_rd_done: got %0d want 2", rd_done); end
   endtask

   task automatic test_overflow_timeout();
      ARVALID = 1; ARREADY = 1; ARLEN = 8'd0; ARADDR = 32'h3000;
      repeat (5) cycle();
      ARVALID = 0; ARREADY = 0;
      n_cmp++; if (err_vec !== 12'h400 || first_err !== 4'd10) begin n_bad++; $display("FAIL overflow: got %h/%0d want 400/10", err_vec, first_err); end
      n_cmp++; if (rd_outst !== 3'd4) begin n_bad++; $display("FAIL overflow_outst: got %0d want 4", rd_outst); end
      repeat (20) cycle();
      n_cmp++; if (err_vec[11] !== 1'b0) begin n_bad++; $display("FAIL timeout_early: got %b want 0", err_vec[11]); end
      for (int i = 0; i < 20; i++) begin
         if (err_vec[11] === 1'b1) break;
         cycle();
      end
      n_cmp++; if (err_vec !== 12'hC00) begin n_bad++; $display("FAIL r_timeout: got %h want c00", err_vec); end
      n_cmp++; if (rd_outst !== 3'd4) begin n_bad++; $display("FAIL timeout_outst: got %0d want 4", rd_outst); end
      pulse_clr();
   endtask

   task automatic test_resp_orphan();
      // AW and its single W beat in the same cycle with an empty queue
      AWVALID = 1; AWREADY = 1; AWLEN = 8'd0;
      WVALID = 1; WREADY = 1; WLAST = 1; WDATA = 32'h77;
      cycle();
      AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0; WLAST = 0;
      n_cmp++; if (err_vec !== 12'h000 || wr_outst !== 3'd1) begin n_bad++; $display("FAIL bypass: got %h/%0d want 000/1", err_vec, wr_outst); end
      b_hs(2'b01);
      n_cmp++; if (err_vec !== 12'h100 || first_err !== 4'd8) begin n_bad++; $display("FAIL bresp_exokay: got %h/%0d want 100/8", err_vec, first_err); end
      b_hs(2'b00);
      n_cmp++; if (err_vec !== 12'h300 || first_err !== 4'd8) begin n_bad++; $display("FAIL b_orphan: got %h/%0d want 300/8", err_vec, first_err); end
      n_cmp++; if (wr_done !== 16'd3) begin n_bad++; $display("FAIL b_orphan_done: got %0d want 3", wr_done); end
      pulse_clr();
      n_cmp++; if (err_vec !== 12'h000 || first_err !== 4'd0) begin n_bad++; $display("FAIL resp_clr: got %h/%0d want 000/0", err_vec, first_err); end
      clr_err = 1; BVALID = 1; BREADY = 1;
      cycle();
      clr_err = 0; BVALID = 0; BREADY = 0;
      n_cmp++; if (err_vec !== 12'h200 || first_err !== 4'd9) begin n_bad++; $display("FAIL clr_with_new: got %h/%0d want 200/9", err_vec, first_err); end
      pulse_clr();
   endtask

   task automatic test_reset_mid_burst();
      aw_hs(8'd3);
      w_hs(1'b0, 32'h1);
      w_hs(1'b0, 32'h2);
      ARESETn = 0;
      idle_inputs();
      #1;
      n_cmp++; if (err_vec !== 12'h000 || err_pulse !== 1'b0 || first_err !== 4'd0) begin n_bad++; $display("FAIL midrst_err: got %h/%b/%0d want 000/0/0", err_vec, err_pulse, first_err); end
      n_cmp++; if (wr_done !== 16'd0 || rd_done !== 16'd0 || wr_outst !== 3'd0 || rd_outst !== 3'd0) begin n_bad++; $display("FAIL midrst_cnt: got %0d/%0d/%0d/%0d want 0/0/0/0", wr_done, rd_done, wr_outst, rd_outst); end
      cycle();
      ARESETn = 1;
      cycle();
      aw_hs(8'd1);
      w_hs(1'b0, 32'h5);
      w_hs(1'b1, 32'h6);
      b_hs(2'b00);
      n_cmp++; if (err_vec !== 12'h000) begin n_bad++; $display("FAIL post_rst_err: got %h want 000", err_vec); end
      n_cmp++; if (wr_done !== 16'd1 || wr_outst !== 3'd0) begin n_bad++; $display("FAIL post_rst_cnt: got %0d/%0d want 1/0", wr_done, wr_outst); end
   endtask

   initial begin
      test_reset();
      test_write_burst();
      test_valid_drop();
      test_wlast_resync();
      test_rlast();
      test_overflow_timeout();
      test_resp_orphan();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
